ofdm_rx_sequencer: RTL



---
 rtl/ofdm_rx_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ofdm_rx_sequencer.sv
// Control FSM for OFDM RX time sync: gates sample capture, sequences metric/peak/CP-removal
// engines by start/done handshakes, then streams the CP-free frame with valid/ready.
module ofdm_rx_sequencer #(
  parameter int CAPTURE_LEN = 2240,
  parameter int BURST_LEN   = 1120,
  parameter int OUT_LEN     = 336,
  parameter int TIMEOUT     = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wren,
  input  logic        tx_done,
  output logic        cap_we,
  output logic [11:0] cap_addr,
  output logic        sync_start,
  input  logic        sync_done,
  output logic        det_start,
  input  logic        det_done,
  input  logic [11:0] det_index,
  output logic [11:0] frame_index,
  output logic        cprm_start,
  input  logic        cprm_done,
  output logic [8:0]  rd_ptr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [2:0]  state,
  output logic        err_timeout,
  output logic        err_range,
  output logic [15:0] frame_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_SYNC    = 3'd2;
  localparam logic [2:0] S_DETECT  = 3'd3;
  localparam logic [2:0] S_CPRM    = 3'd4;
  localparam logic [2:0] S_STREAM  = 3'd5;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [11:0]   CAP_LEN12 = 12'(CAPTURE_LEN);
  localparam logic [11:0]   CAP_LAST  = 12'(CAPTURE_LEN - 1);
  localparam logic [11:0]   IDX_MAX   = 12'(CAPTURE_LEN - BURST_LEN);
  localparam logic [8:0]    PTR_LAST  = 9'(OUT_LEN - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);

  logic [2:0]    state_q;
  logic [11:0]   cap_cnt;
  logic [TW-1:0] tmr;
  logic [8:0]    rd_ptr_q;
  logic [11:0]   frame_index_q;
  logic [15:0]   frame_cnt_q;
  logic          err_timeout_q;
  logic          err_range_q;

  logic in_eng;
  logic start_cyc;
  logic eng_done;
  logic cap_ok;
  logic xfer;

  assign in_eng    = (state_q == S_SYNC) || (state_q == S_DETECT) || (state_q == S_CPRM);
  // The timer is zero only in the first cycle of an engine state, which doubles as the strobe.
  assign start_cyc = in_eng && (tmr == '0);

  always_comb begin
    eng_done = 1'b0;
    case (state_q)
      S_SYNC:   eng_done = sync_done;
      S_DETECT: eng_done = det_done;
      S_CPRM:   eng_done = cprm_done;
      default:  eng_done = 1'b0;
    endcase
  end

  assign cap_ok = wren && !tx_done &&
                  ((state_q == S_IDLE) || ((state_q == S_CAPTURE) && (cap_cnt < CAP_LEN12)));

  assign cap_we      = cap_ok;
  assign cap_addr    = (state_q == S_IDLE) ? 12'd0 : cap_cnt;
  assign sync_start  = start_cyc && (state_q == S_SYNC);
  assign det_start   = start_cyc && (state_q == S_DETECT);
  assign cprm_start  = start_cyc && (state_q == S_CPRM);
  assign out_valid   = (state_q == S_STREAM);
  assign out_last    = out_valid && (rd_ptr_q == PTR_LAST);
  assign xfer        = out_valid && out_ready;
  assign busy        = (state_q != S_IDLE);
  assign state       = state_q;
  assign rd_ptr      = rd_ptr_q;
  assign frame_index = frame_index_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_timeout = err_timeout_q;
  assign err_range   = err_range_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cap_cnt       <= 12'd0;
      tmr           <= '0;
      rd_ptr_q      <= 9'd0;
      frame_index_q <= 12'd0;
      frame_cnt_q   <= 16'd0;
      err_timeout_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else if (tx_done) begin
      // Abort outranks every other event; frame bookkeeping survives it.
      state_q       <= S_IDLE;
      cap_cnt       <= 12'd0;
      tmr           <= '0;
      rd_ptr_q      <= 9'd0;
      err_timeout_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wren) begin
            cap_cnt <= 12'd1;
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (cap_ok) begin
            cap_cnt <= cap_cnt + 12'd1;
            if (cap_cnt == CAP_LAST) begin
              state_q <= S_SYNC;
              tmr     <= '0;
            end
          end
        end
        S_SYNC, S_DETECT, S_CPRM: begin
          if (start_cyc) begin
            tmr <= tmr + 1'b1;
          end else if (eng_done) begin
            tmr <= '0;
            case (state_q)
              S_SYNC: state_q <= S_DETECT;
              S_DETECT: begin
                if (det_index <= IDX_MAX) begin
                  frame_index_q <= det_index;
                  state_q       <= S_CPRM;
                end else begin
                  err_range_q <= 1'b1;
                  state_q     <= S_IDLE;
                end
              end
              default: begin
                rd_ptr_q <= 9'd0;
                state_q  <= S_STREAM;
              end
            endcase
          end else if (tmr == T_LAST) begin
            // Done in the last counted cycle still wins; the flag lands exactly TIMEOUT cycles after start.
            err_timeout_q <= 1'b1;
            tmr           <= '0;
            state_q       <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            if (rd_ptr_q == PTR_LAST) begin
              rd_ptr_q    <= 9'd0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= S_IDLE;
            end else begin
              rd_ptr_q <= rd_ptr_q + 9'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
